// File: rtl/pc_redirect_unit.sv
// Fetch-stage program counter with sequential, PC-relative branch and J-type jump
// sequencing. Every taken redirect is followed by a one-cycle fetch bubble.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             imem_ready,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_offset_sl2,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             pc_valid,
    output logic             redirect,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2
    } state_t;

    // Word alignment is guaranteed even if RESET_PC is given unaligned.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t           state_reg;
    logic [31:0]      pc_reg;
    logic             pc_valid_reg;
    logic             redirect_reg;
    logic [CNT_W-1:0] count_reg;

    logic             advance;
    logic [31:0]      b_target;
    logic [31:0]      j_target;
    logic [CNT_W-1:0] count_next;

    assign pc_plus4 = pc_reg + 32'd4;
    assign advance  = (state_reg == S_RUN) && imem_ready && !stall;
    assign b_target = pc_plus4 + {branch_offset_sl2[31:2], 2'b00};
    assign j_target = {pc_plus4[31:28], jump_index, 2'b00};

    // Saturates at all ones rather than wrapping.
    assign count_next = (count_reg == {CNT_W{1'b1}}) ? count_reg : count_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            pc_reg       <= RESET_PC_ALIGNED;
            pc_valid_reg <= 1'b0;
            redirect_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            redirect_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_RUN;
                        pc_valid_reg <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (advance) begin
                        if (jump || branch_taken) begin
                            pc_reg       <= jump ? j_target : b_target;
                            state_reg    <= S_BUBBLE;
                            pc_valid_reg <= 1'b0;
                            redirect_reg <= 1'b1;
                            count_reg    <= count_next;
                        end else begin
                            pc_reg <= pc_plus4;
                        end
                    end
                end
                S_BUBBLE: begin
                    if (!stall) begin
                        state_reg    <= S_RUN;
                        pc_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    pc_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc             = pc_reg;
    assign pc_valid       = pc_valid_reg;
    assign redirect       = redirect_reg;
    assign redirect_count = count_reg;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a vector table walks fetch, branches, jumps,
// stalls and wrap-around; hand sequences cover async reset and a 2-bit counter.
`timescale 1ns/1ps
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, imem_ready, stall, branch_taken, jump;
    logic [31:0] branch_offset_sl2;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4, pc2, pc_plus4_2;
    logic        pc_valid, redirect, pc_valid2, redirect2;
    logic [15:0] redirect_count;
    logic [1:0]  redirect_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready),
        .stall(stall), .branch_taken(branch_taken), .branch_offset_sl2(branch_offset_sl2),
        .jump(jump), .jump_index(jump_index), .pc(pc), .pc_plus4(pc_plus4),
        .pc_valid(pc_valid), .redirect(redirect), .redirect_count(redirect_count)
    );

    // Narrow-counter copy driven by the same stimulus, for saturation.
    pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready),
        .stall(stall), .branch_taken(branch_taken), .branch_offset_sl2(branch_offset_sl2),
        .jump(jump), .jump_index(jump_index), .pc(pc2), .pc_plus4(pc_plus4_2),
        .pc_valid(pc_valid2), .redirect(redirect2), .redirect_count(redirect_count2)
    );

    typedef struct {
        logic        st;
        logic        rdy;
        logic        stl;
        logic        br;
        logic        jmp;
        logic [31:0] off;
        logic [25:0] idx;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_red;
        int          e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        start             = v.st;
        imem_ready        = v.rdy;
        stall             = v.stl;
        branch_taken      = v.br;
        jump              = v.jmp;
        branch_offset_sl2 = v.off;
        jump_index        = v.idx;
    endtask

    task automatic check_all(input int i, input vec_t v);
        int sat;
        sat = (v.e_cnt > 3) ? 3 : v.e_cnt;
        chk("pc", i, pc, v.e_pc);
        chk("pc_plus4", i, pc_plus4, v.e_pc + 32'd4);
        chk("pc_valid", i, {31'b0, pc_valid}, {31'b0, v.e_valid});
        chk("redirect", i, {31'b0, redirect}, {31'b0, v.e_red});
        chk("redirect_count", i, {16'b0, redirect_count}, v.e_cnt);
        chk("count_w2", i, {30'b0, redirect_count2}, sat);
        $display("step %0d: pc=0x%08h valid=%0b redirect=%0b count=%0d count2=%0d",
                 i, pc, pc_valid, redirect, redirect_count, redirect_count2);
    endtask

    initial begin
        vec_t v;
        //                 st rdy stl br jmp off            idx          e_pc          v  r  cnt
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h0000_0000,1'b1,1'b0,0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h0000_0004,1'b1,1'b0,0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h0000_0008,1'b1,1'b0,0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h0000_000C,1'b1,1'b0,0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_00F0,26'h0,       32'h0000_0100,1'b0,1'b1,1});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_0040,26'h0,       32'h0000_0100,1'b1,1'b0,1});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,32'hFFFF_FFF0,26'h0,       32'h0000_00F4,1'b0,1'b1,2});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        26'h0,       32'h0000_00F4,1'b0,1'b0,2});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h0000_00F4,1'b1,1'b0,2});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,1'b1,32'h0000_0040,26'h3,       32'h0000_00F4,1'b1,1'b0,2});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1,32'h0000_0040,26'h3,       32'h0000_00F4,1'b1,1'b0,2});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,32'h3FFF_FF18,26'h0,       32'h4000_0010,1'b0,1'b1,3});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h4000_0010,1'b1,1'b0,3});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,32'h0000_0100,26'h40,      32'h4000_0100,1'b0,1'b1,4});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h4000_0100,1'b1,1'b0,4});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,32'hBFFF_FEF7,26'h0,       32'hFFFF_FFF8,1'b0,1'b1,5});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'hFFFF_FFF8,1'b1,1'b0,5});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_0008,26'h0,       32'h0000_0004,1'b0,1'b1,6});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h0000_0004,1'b1,1'b0,6});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,32'hFFFF_FFF4,26'h0,       32'hFFFF_FFFC,1'b0,1'b1,7});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'hFFFF_FFFC,1'b1,1'b0,7});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        26'h0,       32'h0000_0000,1'b1,1'b0,7});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1,32'h0,        26'h3FF_FFFF,32'h0FFF_FFFC,1'b0,1'b1,8});

        rst_n = 1'b0;
        v = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,26'h0,32'h0,1'b0,1'b0,0};
        drive(v);
        repeat (3) @(posedge clk);
        #1;
        check_all(-1, v);
        rst_n = 1'b1;

        // Idle must ignore redirects and imem_ready until start.
        v = '{1'b0,1'b1,1'b0,1'b1,1'b1,32'h40,26'h5,32'h0,1'b0,1'b0,0};
        drive(v);
        @(posedge clk);
        #1;
        check_all(-2, v);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_all(i, vecs[i]);
        end

        // Now in the bubble after the jump with redirect high: async reset mid-bubble.
        rst_n = 1'b0;
        #1;
        v = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,26'h0,32'h0,1'b0,1'b0,0};
        check_all(100, v);
        #2;
        rst_n = 1'b1;

        // After reset, start again and check the first fetch comes from RESET_PC.
        v = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,26'h0,32'h0,1'b1,1'b0,0};
        drive(v);
        @(posedge clk);
        #1;
        check_all(101, v);
        v = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,26'h0,32'h4,1'b1,1'b0,0};
        drive(v);
        @(posedge clk);
        #1;
        check_all(102, v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
